// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, total helpers and sync polarity type
package vga_pkg;

    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    // 640x480 @ 60 Hz (25.175 MHz nominal pixel rate)
    localparam int unsigned VGA640_H_DISPLAY = 640;
    localparam int unsigned VGA640_H_FRONT   = 16;
    localparam int unsigned VGA640_H_SYNC    = 96;
    localparam int unsigned VGA640_H_BACK    = 48;
    localparam int unsigned VGA640_V_DISPLAY = 480;
    localparam int unsigned VGA640_V_BOTTOM  = 10;
    localparam int unsigned VGA640_V_SYNC    = 2;
    localparam int unsigned VGA640_V_TOP     = 33;
    localparam sync_pol_e   VGA640_HSYNC_POL = SYNC_ACTIVE_LOW;
    localparam sync_pol_e   VGA640_VSYNC_POL = SYNC_ACTIVE_LOW;

    function automatic int unsigned h_total(input int unsigned disp, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return disp + front + sync + back;
    endfunction

    function automatic int unsigned v_total(input int unsigned disp, input int unsigned bottom,
                                            input int unsigned sync, input int unsigned top);
        return disp + bottom + sync + top;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - enabled shift register with per-bit reset value (DEPTH 0 = wire)
module vga_delay_line #(
    parameter int unsigned      WIDTH   = 3,
    parameter int unsigned      DEPTH   = 0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_bypass;
            assign unused_bypass = ^{clk, reset_n, en_i};
            assign data_o        = data_i;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        stage_q[i] <= RST_VAL;
                    end
                end else if (en_i) begin
                    stage_q[0] <= data_i;
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign data_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator with pixel enable and sync delay line
// Optional frame counter output enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_DISPLAY  = VGA640_H_DISPLAY,
    parameter int unsigned H_FRONT    = VGA640_H_FRONT,
    parameter int unsigned H_SYNC     = VGA640_H_SYNC,
    parameter int unsigned H_BACK     = VGA640_H_BACK,
    parameter int unsigned V_DISPLAY  = VGA640_V_DISPLAY,
    parameter int unsigned V_BOTTOM   = VGA640_V_BOTTOM,
    parameter int unsigned V_SYNC     = VGA640_V_SYNC,
    parameter int unsigned V_TOP      = VGA640_V_TOP,
    parameter logic        HSYNC_POL  = 1'(VGA640_HSYNC_POL),
    parameter logic        VSYNC_POL  = 1'(VGA640_VSYNC_POL),
    parameter int unsigned PIPE_DELAY = 0,
    parameter int unsigned CNT_W      = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pix_en,
    output logic [CNT_W-1:0] hpos,
    output logic [CNT_W-1:0] vpos,
    output logic             hsync,
    output logic             vsync,
    output logic             display_on,
    output logic             line_start,
    output logic             frame_start,
    output logic             vblank
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int unsigned      H_TOTAL      = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned      V_TOTAL      = v_total(V_DISPLAY, V_BOTTOM, V_SYNC, V_TOP);
    localparam int unsigned      H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int unsigned      V_SYNC_START = V_DISPLAY + V_BOTTOM;
    localparam logic [CNT_W-1:0] H_LAST       = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST       = CNT_W'(V_TOTAL - 1);
    // Physical {hsync, vsync, display_on} levels while idle or in reset
    localparam logic [2:0]       SYNC_IDLE    = {~HSYNC_POL, ~VSYNC_POL, 1'b0};

    generate
        if (64'(H_TOTAL) > (64'd1 << CNT_W)) begin : g_chk_h_total
            $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
        end
        if (64'(V_TOTAL) > (64'd1 << CNT_W)) begin : g_chk_v_total
            $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
        end
        if (PIPE_DELAY > 7) begin : g_chk_pipe_delay
            $error("vga_timing_gen: PIPE_DELAY must be 0..7");
        end
    endgenerate

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             h_last, v_last;
    logic [31:0]      h_ext, v_ext;
    logic             hs_raw, vs_raw, de_raw;
    logic [2:0]       sync_q, sync_d, sync_out;

    assign h_last = (h_cnt_q == H_LAST);
    assign v_last = (v_cnt_q == V_LAST);

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? '0 : v_cnt_q + CNT_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_ext  = 32'(h_cnt_q);
    assign v_ext  = 32'(v_cnt_q);
    assign hs_raw = (h_ext >= H_SYNC_START) && (h_ext < H_SYNC_START + H_SYNC);
    assign vs_raw = (v_ext >= V_SYNC_START) && (v_ext < V_SYNC_START + V_SYNC);
    assign de_raw = (h_ext < H_DISPLAY) && (v_ext < V_DISPLAY);

    // Polarity is applied before the first register so every stage holds pin levels
    assign sync_d = {hs_raw ~^ HSYNC_POL, vs_raw ~^ VSYNC_POL, de_raw};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= SYNC_IDLE;
        end else if (pix_en) begin
            sync_q <= sync_d;
        end
    end

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (SYNC_IDLE)
    ) u_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (pix_en),
        .data_i  (sync_q),
        .data_o  (sync_out)
    );

    assign hpos        = h_cnt_q;
    assign vpos        = v_cnt_q;
    assign hsync       = sync_out[2];
    assign vsync       = sync_out[1];
    assign display_on  = sync_out[0];
    assign line_start  = pix_en && h_last;
    assign frame_start = line_start && v_last;
    assign vblank      = (v_ext >= V_DISPLAY);

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
        end else if (frame_start) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/TV raster timing generator, successor to the fixed 640x480 sync generator. Produces horizontal/vertical counters, sync and blanking signals, and per-line and per-frame strobes. Adds a pixel-clock enable so it can run from the 100 MHz board clock, programmable sync polarity, and a parametrised pipeline-delay line. The delay line aligns sync and display_on with downstream character/font fetch latency; back-porch values are no longer hand-trimmed. It sits between the clock domain root and the video pixel pipelines (terminal, sprite, bitmap).

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, back porch (pixels)
V_DISPLAY, 480, visible lines
V_BOTTOM, 10, bottom border / front porch (lines)
V_SYNC, 2, vsync width (lines)
V_TOP, 33, top border / back porch (lines)
HSYNC_POL, 0, active level of hsync (0 = active-low, VGA 640x480)
VSYNC_POL, 0, active level of vsync
PIPE_DELAY, 0, pixel-enabled stages of delay applied to hsync/vsync/display_on (0..7)
CNT_W, 10, counter width; H_TOTAL and V_TOTAL must each be ≤ 2^CNT_W

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pix_en  in  1  pixel-clock enable; all timing advances only on cycles where it is high
hpos  out  CNT_W  current horizontal position, 0..H_TOTAL-1
vpos  out  CNT_W  current vertical position, 0..V_TOTAL-1
hsync  out  1  horizontal sync at HSYNC_POL level, delayed PIPE_DELAY
vsync  out  1  vertical sync at VSYNC_POL level, delayed PIPE_DELAY
display_on  out  1  visible-area flag, delayed PIPE_DELAY
line_start  out  1  one-clk strobe: pix_en high and hpos==H_TOTAL-1 (next pixel is hpos 0)
frame_start  out  1  one-clk strobe: line_start and vpos==V_TOTAL-1
vblank  out  1  vpos ≥ V_DISPLAY, undelayed (CPU/frame-swap use)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset_n). Assertion forces all state immediately; deassertion is used as-is, with the synchroniser living outside the block.
- Derived constants: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. H_SYNC_START = H_DISPLAY+H_FRONT. V_SYNC_START = V_DISPLAY+V_BOTTOM.
- Reset values:
  - hpos = 0, vpos = 0.
  - All delay stages and hsync/vsync held at their inactive level (~POL).
  - display_on = 0, line_start = 0, frame_start = 0, vblank = 0.
- Counting (on pix_en only):
  - hpos increments; at H_TOTAL-1 it wraps to 0 and vpos increments.
  - vpos wraps to 0 at V_TOTAL-1 in the same cycle hpos wraps.
  - pix_en low: all registers hold; strobes are 0.
- Raw terms are combinational from the current hpos/vpos:
  - hs_raw = H_SYNC_START ≤ hpos < H_SYNC_START+H_SYNC
  - vs_raw = V_SYNC_START ≤ vpos < V_SYNC_START+V_SYNC
  - de_raw = hpos < H_DISPLAY && vpos < V_DISPLAY
- Output stage: raw terms are registered once (on pix_en), then pass through PIPE_DELAY further pix_en-gated stages.
  - Total latency from counter value to hsync/vsync/display_on is 1+PIPE_DELAY pixel enables.
  - hsync = hs_d XNOR HSYNC_POL (output equals POL when active); vsync likewise.
- Strobes are combinational from counters and pix_en; they are not delayed.
- Boundary: with pix_en tied high, a frame is exactly H_TOTAL*V_TOTAL clocks between frame_start pulses.
- Reset asserted mid-line: outputs go inactive within the same cycle (async). The first pix_en after release counts hpos 0→1.
- Elaboration-time checks: H_TOTAL ≤ 2^CNT_W, V_TOTAL ≤ 2^CNT_W, PIPE_DELAY ≤ 7; any violation raises an error via a generate-block $error.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined: adds output frame_cnt [15:0].
  - Resets to 0 and increments on every frame_start, wrapping at 65535.
  - Used for blink/animation timing.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Decomposition:
- Shared package vga_pkg holds:
  - VGA 640x480@60 timing constants as a named set (the defaults above).
  - Helper functions h_total()/v_total().
  - The sync-polarity enum (SYNC_ACTIVE_LOW / SYNC_ACTIVE_HIGH).
- One natural sub-module: vga_delay_line. It is a width-3, depth-PIPE_DELAY shift register with enable, async active-low reset and a per-bit reset value, and is reused by downstream pixel pipelines.

Test Plan:
- Defaults, pix_en=1, release reset: hsync (active-low) goes low exactly when the registered hpos=656 term lands and stays low 96 clocks. frame_start pulses are 420000 clocks apart.
- vsync low for exactly 2 lines (1600 clocks) starting on line 490. vblank is high for vpos 480..524.
- pix_en toggled every 4th clock (25 MHz from 100 MHz): hpos advances once per 4 clocks. Frame period is 1680000 clocks and the strobes are one clock wide.
- PIPE_DELAY=2: display_on rises 3 pix_en after hpos=0 on line 0 and falls 3 pix_en after hpos=640.
- HSYNC_POL=1, VSYNC_POL=1: the sync waveforms are inverted. During reset, hsync=vsync=0 (the inactive level).
- Assert reset_n low at hpos=300, vpos=200 with no clock edge: outputs reach reset values immediately. After release, the count restarts at 0,0. With VGA_TIMING_FRAME_CNT_EN defined, frame_cnt=0 after reset and frame_cnt=3 after 3 frame_start pulses.
